// File: rtl/lut_rom_param.sv
// Run-time programmable lookup table with a registered valid/ready read port,
// a synchronous write port and a post-reset sequencer that fills every entry.
module lut_rom_param #(
  parameter int               WIDTH      = 2,
  parameter int               DEPTH      = 8,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0,
  localparam int              ADDR_W     = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [ADDR_W-1:0] ADDR,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [WIDTH-1:0]  OUT,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic [WIDTH-1:0]  WDATA,
  output logic              BUSY
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]    out_q, out_d;
  logic                out_vld_q, out_vld_d;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [WIDTH-1:0]    mem_wdata;

  logic                rd_in_range;
  logic                wr_in_range;
  logic                accept;
  logic [WIDTH-1:0]    rd_data;

  assign rd_in_range = ({1'b0, ADDR}  < DEPTH_L);
  assign wr_in_range = ({1'b0, WADDR} < DEPTH_L);
  // Out-of-range reads return zero rather than whatever a wrapped index would hold.
  assign rd_data     = rd_in_range ? mem_q[ADDR] : '0;

  assign BUSY      = (state_q == ST_INIT);
  assign IN_READY  = (state_q == ST_RUN) && (!out_vld_q || OUT_READY);
  assign accept    = IN_VALID && IN_READY;
  assign OUT       = out_q;
  assign OUT_VALID = out_vld_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    out_d     = out_q;
    out_vld_d = out_vld_q;
    mem_we    = 1'b0;
    mem_waddr = WADDR;
    mem_wdata = WDATA;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = INIT_VALUE;
        cnt_d     = cnt_q + ADDR_W'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        mem_we = WE && wr_in_range;
        if (accept) begin
          out_d     = rd_data;
          out_vld_d = 1'b1;
        end else if (out_vld_q && OUT_READY) begin
          out_vld_d = 1'b0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
    end
  end

  // Table storage is deliberately left out of reset; the init sequence overwrites it.
  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_lut_rom_param.sv
// Directed bench for lut_rom_param: an 8-entry instance and a 6-entry instance.
module tb_lut_rom_param;

  logic       CLK = 1'b0;
  always #5 CLK = ~CLK;

  // DEPTH=8, INIT_VALUE=0 instance
  logic       rst_n, iv, ir, ov, ordy, we, busy;
  logic [2:0] addr, waddr;
  logic [1:0] wdata, dout;

  // DEPTH=6, INIT_VALUE=1 instance
  logic       rst_n6, iv6, ir6, ov6, ordy6, we6, busy6;
  logic [2:0] addr6, waddr6;
  logic [1:0] wdata6, dout6;

  int nvec = 0;
  int nerr = 0;
  logic [1:0] tbl [8];

  lut_rom_param #(.WIDTH(2), .DEPTH(8), .INIT_VALUE(2'b00)) u_dut8 (
    .CLK(CLK), .RST_N(rst_n), .IN_VALID(iv), .IN_READY(ir), .ADDR(addr),
    .OUT_VALID(ov), .OUT_READY(ordy), .OUT(dout), .WE(we), .WADDR(waddr),
    .WDATA(wdata), .BUSY(busy)
  );

  lut_rom_param #(.WIDTH(2), .DEPTH(6), .INIT_VALUE(2'b01)) u_dut6 (
    .CLK(CLK), .RST_N(rst_n6), .IN_VALID(iv6), .IN_READY(ir6), .ADDR(addr6),
    .OUT_VALID(ov6), .OUT_READY(ordy6), .OUT(dout6), .WE(we6), .WADDR(waddr6),
    .WDATA(wdata6), .BUSY(busy6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    tbl[0] = 2'b11; tbl[1] = 2'b11; tbl[2] = 2'b10; tbl[3] = 2'b00;
    tbl[4] = 2'b01; tbl[5] = 2'b01; tbl[6] = 2'b10; tbl[7] = 2'b01;
    rst_n = 1'b0; iv = 1'b0; ordy = 1'b1; addr = '0; we = 1'b0; waddr = '0; wdata = '0;
    rst_n6 = 1'b0; iv6 = 1'b0; ordy6 = 1'b1; addr6 = '0; we6 = 1'b0; waddr6 = '0; wdata6 = '0;

    // Reset state
    #3;
    chk("rst_out", dout, 0);
    chk("rst_ovalid", ov, 0);
    chk("rst_busy", busy, 1);
    chk("rst_inready", ir, 0);

    // Init: BUSY for 8 edges; traffic and writes offered meanwhile must be ignored
    #14 rst_n = 1'b1;
    iv = 1'b1; addr = 3'd5; we = 1'b1; waddr = 3'd5; wdata = 2'b11;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("init_busy%0d", i), busy, 1);
      chk($sformatf("init_inready%0d", i), ir, 0);
      chk($sformatf("init_ovalid%0d", i), ov, 0);
      step();
    end
    we = 1'b0;
    chk("run_busy", busy, 0);
    chk("run_inready", ir, 1);
    step();
    chk("rd5_out", dout, 0);
    chk("rd5_ovalid", ov, 1);

    // Load the table, then stream reads back-to-back
    iv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; waddr = 3'(i); wdata = tbl[i];
      step();
      if (i == 0) begin
        chk("retire_ovalid", ov, 0);
        chk("retire_out_hold", dout, 0);
      end
    end
    we = 1'b0;
    iv = 1'b1;
    for (int i = 0; i < 8; i++) begin
      addr = 3'(i);
      step();
      chk($sformatf("stream_out%0d", i), dout, tbl[i]);
      chk($sformatf("stream_ovalid%0d", i), ov, 1);
    end

    // Backpressure: OUT holds while stalled, even across a write to the read address
    addr = 3'd2;
    step();
    chk("rd2_out", dout, 2'b10);
    ordy = 1'b0; addr = 3'd3;
    we = 1'b1; waddr = 3'd2; wdata = 2'b01;
    #1 chk("stall_inready", ir, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      we = 1'b0;
      chk($sformatf("stall_out%0d", i), dout, 2'b10);
      chk($sformatf("stall_ovalid%0d", i), ov, 1);
      chk($sformatf("stall_inready%0d", i), ir, 0);
    end
    ordy = 1'b1;
    #1 chk("unstall_inready", ir, 1);
    step();
    chk("rd3_out", dout, 2'b00);
    addr = 3'd2;
    step();
    chk("rd2_new_out", dout, 2'b01);

    // Same-cycle read and write: old data first, new data next cycle
    addr = 3'd3; we = 1'b1; waddr = 3'd3; wdata = 2'b11;
    step();
    we = 1'b0;
    chk("rbw_old", dout, 2'b00);
    step();
    chk("rbw_new", dout, 2'b11);

    // Asynchronous reset in the middle of a stream
    addr = 3'd0;
    step();
    chk("pre_rst_out", dout, 2'b11);
    chk("pre_rst_ovalid", ov, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ovalid", ov, 0);
    chk("arst_out", dout, 0);
    chk("arst_busy", busy, 1);
    chk("arst_inready", ir, 0);
    @(posedge CLK);
    #2 rst_n = 1'b1;
    iv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("reinit_busy%0d", i), busy, 1);
      step();
    end
    chk("reinit_done", busy, 0);
    iv = 1'b1; addr = 3'd0;
    step();
    chk("reinit_rd0", dout, 2'b00);
    chk("reinit_ovalid", ov, 1);
    iv = 1'b0;

    // DEPTH=6 instance: 6-cycle init and out-of-range handling
    @(negedge CLK);
    rst_n6 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("d6_busy%0d", i), busy6, 1);
      step();
    end
    chk("d6_run_busy", busy6, 0);
    chk("d6_inready", ir6, 1);
    iv6 = 1'b1; addr6 = 3'd4;
    step();
    chk("d6_init_rd4", dout6, 2'b01);
    iv6 = 1'b1; addr6 = 3'd7;
    step();
    chk("d6_rd7", dout6, 2'b00);
    chk("d6_rd7_ovalid", ov6, 1);
    iv6 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      we6 = 1'b1; waddr6 = 3'(i); wdata6 = (i % 2 == 0) ? 2'b01 : 2'b10;
      step();
    end
    we6 = 1'b1; waddr6 = 3'd6; wdata6 = 2'b11;
    step();
    we6 = 1'b0; iv6 = 1'b1; addr6 = 3'd6;
    step();
    chk("d6_rd6", dout6, 2'b00);
    for (int i = 0; i < 6; i++) begin
      addr6 = 3'(i);
      step();
      chk($sformatf("d6_keep%0d", i), dout6, (i % 2 == 0) ? 2'b01 : 2'b10);
    end
    iv6 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
